// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient loader.
//   coef_state_e    : frame-parsing FSM states
//   COEF_RESET_TAP0 : tap 0 value after reset (identity filter)
//   SPI_BYTE_BITS   : bits per SPI byte
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR    = 2'd1,
    ST_DATA    = 2'd2,
    ST_DISCARD = 2'd3
  } coef_state_e;

  localparam logic [7:0]  COEF_RESET_TAP0 = 8'h7F;
  localparam int unsigned SPI_BYTE_BITS   = 8;

endpackage

// File: rtl/fir_coef_loader_spi_byte_rx.sv
// spi_byte_rx: SPI mode-0 byte receiver, oversampled in the clk domain.
// Ports:
//   clk, resetN          system clock, async active-low reset
//   spiClk, mosi, cs     raw SPI pins (asynchronous to clk)
//   byteValid            one-clk pulse when the 8th bit of a byte is shifted in
//   byteData             completed byte (valid with byteValid)
//   csFall, csRise       one-clk pulses on synchronised cs edges
//   partialByte          bit counter (after this cycle's capture) is mid-byte
module spi_byte_rx
  import fir_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic       spiClk,
  input  logic       mosi,
  input  logic       cs,
  output logic       byteValid,
  output logic [7:0] byteData,
  output logic       csFall,
  output logic       csRise,
  output logic       partialByte
);

  logic       sclk_meta, sclk_sync, sclk_prev;
  logic       mosi_meta, mosi_sync;
  logic       cs_meta, cs_sync, cs_prev;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift_reg;
  logic       sclk_rise, capture;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
    end else begin
      sclk_meta <= spiClk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
      cs_meta   <= cs;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
    end
  end

  assign sclk_rise = sclk_sync & ~sclk_prev;
  assign csFall    = cs_prev & ~cs_sync;
  assign csRise    = ~cs_prev & cs_sync;
  assign capture   = sclk_rise & ~cs_sync;

  // A new frame restarts the count; a capture in the same cycle is bit 0 of it.
  always_comb begin
    bit_cnt_n = bit_cnt;
    if (csFall) begin
      bit_cnt_n = capture ? 3'd1 : 3'd0;
    end else if (capture) begin
      bit_cnt_n = bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      bit_cnt <= bit_cnt_n;
      if (capture) begin
        shift_reg <= {shift_reg[SPI_BYTE_BITS-2:0], mosi_sync};
      end
    end
  end

  // Byte completes combinationally with its last bit; a stale count from an
  // aborted frame must not complete a byte on the first edge of a new frame.
  assign byteValid   = capture & ~csFall & (bit_cnt == 3'd7);
  assign byteData    = {shift_reg[SPI_BYTE_BITS-2:0], mosi_sync};
  assign partialByte = (bit_cnt_n != 3'd0);

endmodule

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: SPI coefficient loader with shadow/active banks.
// Frame format on SPI: first byte = start tap address, following bytes =
// coefficients written to consecutive taps. A validated frame is committed
// to the active bank on the next sampleStrobe.
// Ports:
//   clk, resetN      system clock, async active-low reset
//   spiClk/mosi/cs   SPI pins (mode 0, MSB first, cs active low)
//   sampleStrobe     engine sample-boundary pulse
//   coefs            active bank, tap i at [i*DataWidth +: DataWidth]
//   coefUpdated      pulse in the cycle after a commit
//   commitPending    validated shadow bank awaiting sampleStrobe
//   frameError       sticky frame error, cleared at next cs fall
// Build option: define SYMMETRIC_COEF_EN to mirror each write to tap
// NTaps-1-addr; accepted addresses then shrink to 0..(NTaps-1)/2.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int unsigned NTaps     = 13,
  parameter int unsigned DataWidth = 8
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       spiClk,
  input  logic                       mosi,
  input  logic                       cs,
  input  logic                       sampleStrobe,
  output logic [NTaps*DataWidth-1:0] coefs,
  output logic                       coefUpdated,
  output logic                       commitPending,
  output logic                       frameError
);

  localparam int unsigned BANK_W = NTaps * DataWidth;
`ifdef SYMMETRIC_COEF_EN
  localparam int unsigned ADDR_LIMIT = (NTaps - 1) / 2 + 1;
`else
  localparam int unsigned ADDR_LIMIT = NTaps;
`endif
  localparam logic [8:0]        LIMIT_W    = 9'(ADDR_LIMIT);
  localparam logic [BANK_W-1:0] BANK_RESET = BANK_W'(COEF_RESET_TAP0);

  logic       byte_valid, cs_fall, cs_rise, partial_byte;
  logic [7:0] byte_data;

  spi_byte_rx u_rx (
    .clk         (clk),
    .resetN      (resetN),
    .spiClk      (spiClk),
    .mosi        (mosi),
    .cs          (cs),
    .byteValid   (byte_valid),
    .byteData    (byte_data),
    .csFall      (cs_fall),
    .csRise      (cs_rise),
    .partialByte (partial_byte)
  );

  coef_state_e       state, state_n;
  logic [8:0]        addr, addr_n;
  logic [8:0]        wr_cnt, wr_cnt_n;
  logic [8:0]        mirror_addr;
  logic              ferr_n;
  logic              wr_en;
  logic              set_pending;
  logic              commit;
  logic [BANK_W-1:0] shadow;

  assign mirror_addr = 9'(NTaps - 1) - addr;
  assign commit      = commitPending & sampleStrobe;

  // Byte handling is evaluated before the cs-rise qualification so a byte
  // completing in the same cycle as cs rising counts toward the commit.
  always_comb begin
    state_n     = state;
    addr_n      = addr;
    wr_cnt_n    = wr_cnt;
    ferr_n      = frameError;
    wr_en       = 1'b0;
    set_pending = 1'b0;
    if (cs_fall) begin
      state_n  = ST_ADDR;
      wr_cnt_n = '0;
      ferr_n   = 1'b0;
    end else begin
      if (byte_valid) begin
        case (state)
          ST_ADDR: begin
            if ({1'b0, byte_data} < LIMIT_W) begin
              addr_n  = {1'b0, byte_data};
              state_n = ST_DATA;
            end else begin
              ferr_n  = 1'b1;
              state_n = ST_DISCARD;
            end
          end
          ST_DATA: begin
            if (addr < LIMIT_W) begin
              wr_en    = 1'b1;
              addr_n   = addr + 9'd1;
              wr_cnt_n = wr_cnt + 9'd1;
            end else begin
              ferr_n  = 1'b1;
              state_n = ST_DISCARD;
            end
          end
          default: ;
        endcase
      end
      if (cs_rise) begin
        if (state != ST_IDLE) begin
          if (partial_byte) begin
            ferr_n = 1'b1;
          end else if (state_n == ST_DATA && wr_cnt_n != '0 && !ferr_n) begin
            set_pending = 1'b1;
          end
        end
        state_n = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= ST_IDLE;
      addr       <= '0;
      wr_cnt     <= '0;
      frameError <= 1'b0;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      wr_cnt     <= wr_cnt_n;
      frameError <= ferr_n;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shadow <= BANK_RESET;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NTaps; i++) begin
`ifdef SYMMETRIC_COEF_EN
        if (9'(i) == addr || 9'(i) == mirror_addr) begin
`else
        if (9'(i) == addr) begin
`endif
          shadow[i*DataWidth +: DataWidth] <= byte_data;
        end
      end
    end
  end

  // A pending commit always copies the shadow as it stands at the strobe,
  // so a later frame arriving first simply updates what gets committed.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      coefs         <= BANK_RESET;
      commitPending <= 1'b0;
      coefUpdated   <= 1'b0;
    end else begin
      if (commit) begin
        coefs <= shadow;
      end
      commitPending <= set_pending | (commitPending & ~commit);
      coefUpdated   <= commit;
    end
  end

`ifndef SYMMETRIC_COEF_EN
  logic unused_mirror;
  assign unused_mirror = ^mirror_addr;
`endif

endmodule

// File: tb/tb_fir_coef_loader.sv
module tb_fir_coef_loader;

  localparam int NT = 13;
  localparam int W  = NT * 8;
`ifdef SYMMETRIC_COEF_EN
  localparam int LIMIT = (NT - 1) / 2 + 1;
`else
  localparam int LIMIT = NT;
`endif

  logic         clk = 1'b0;
  logic         resetN, spiClk, mosi, cs, sampleStrobe;
  logic [W-1:0] coefs;
  logic         coefUpdated, commitPending, frameError;

  fir_coef_loader #(.NTaps(NT), .DataWidth(8)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .spiClk        (spiClk),
    .mosi          (mosi),
    .cs            (cs),
    .sampleStrobe  (sampleStrobe),
    .coefs         (coefs),
    .coefUpdated   (coefUpdated),
    .commitPending (commitPending),
    .frameError    (frameError)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: tap arrays plus frame-level flags.
  logic [7:0] m_shadow [NT];
  logic [7:0] m_active [NT];
  bit         m_pending, m_err;

  logic [7:0] fbuf [32];
  int         flen, fbits;

  function automatic logic [W-1:0] pack_active();
    logic [W-1:0] v;
    for (int i = 0; i < NT; i++) v[i*8 +: 8] = m_active[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      m_shadow[i] = (i == 0) ? 8'h7F : 8'h00;
      m_active[i] = (i == 0) ? 8'h7F : 8'h00;
    end
    m_pending = 0;
    m_err     = 0;
  endtask

  task automatic model_frame();
    int a, writes;
    bit err;
    writes = 0;
    err    = 0;
    if (flen > 0) begin
      a = int'(fbuf[0]);
      if (a >= LIMIT) err = 1;
      for (int k = 1; k < flen && !err; k++) begin
        if (a < LIMIT) begin
          m_shadow[a] = fbuf[k];
`ifdef SYMMETRIC_COEF_EN
          m_shadow[NT-1-a] = fbuf[k];
`endif
          a++;
          writes++;
        end else begin
          err = 1;
        end
      end
    end
    if (fbits != 0) err = 1;
    m_err = err;
    if (!err && writes > 0) m_pending = 1;
  endtask

  task automatic send_bit(input logic b);
    mosi = b;
    #40 spiClk = 1'b1;
    #40 spiClk = 1'b0;
  endtask

  task automatic send_frame();
    logic [7:0] byt;
    cs = 1'b0;
    #80;
    for (int k = 0; k < flen; k++) begin
      byt = fbuf[k];
      for (int b = 7; b >= 0; b--) send_bit(byt[b]);
    end
    for (int k = 0; k < fbits; k++) send_bit(1'($urandom_range(0, 1)));
    #80 cs = 1'b1;
    repeat (6) @(negedge clk);
    model_frame();
  endtask

  task automatic check_status(input string tag);
    check({tag, "_pend"}, W'(commitPending), W'(m_pending));
    check({tag, "_ferr"}, W'(frameError), W'(m_err));
    check({tag, "_coefs"}, coefs, pack_active());
  endtask

  task automatic strobe(input string tag);
    bit exp_upd;
    @(negedge clk);
    sampleStrobe = 1'b1;
    exp_upd = m_pending;
    if (m_pending) begin
      for (int i = 0; i < NT; i++) m_active[i] = m_shadow[i];
      m_pending = 0;
    end
    @(negedge clk);
    sampleStrobe = 1'b0;
    check({tag, "_upd"}, W'(coefUpdated), W'(exp_upd));
    check({tag, "_coefs"}, coefs, pack_active());
    check({tag, "_pend"}, W'(commitPending), W'(m_pending));
    @(negedge clk);
    check({tag, "_upd_end"}, W'(coefUpdated), W'(0));
  endtask

  initial begin
    resetN = 1'b0; spiClk = 1'b0; mosi = 1'b0; cs = 1'b1; sampleStrobe = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_status("reset");
    check("reset_upd", W'(coefUpdated), W'(0));
    resetN = 1'b1;
    repeat (4) @(negedge clk);

    // Full bank load.
    fbuf[0] = 8'h00;
    for (int i = 1; i <= 13; i++) fbuf[i] = 8'(i * 16);
    flen = 14; fbits = 0;
    send_frame();
    check_status("full");
    strobe("full_strobe");

    // Single tap, long wait before strobe.
    fbuf[0] = 8'h05; fbuf[1] = 8'hAA; flen = 2; fbits = 0;
    send_frame();
    repeat (50) @(negedge clk);
    check_status("tap5_wait");
    strobe("tap5_strobe");
    check("tap5_val", W'(coefs[5*8 +: 8]), W'(8'hAA));

    // Address out of range, then cs fall clears the error.
    fbuf[0] = 8'h0D; fbuf[1] = 8'h11; flen = 2; fbits = 0;
    send_frame();
    check_status("badaddr");
    cs = 1'b0;
    repeat (6) @(negedge clk);
    check("ferr_clear", W'(frameError), W'(0));
    cs = 1'b1;
    repeat (6) @(negedge clk);
    m_err = 0;
    check_status("empty");

    // Overrun past the last tap.
    fbuf[0] = 8'h0B; fbuf[1] = 8'h01; fbuf[2] = 8'h02; fbuf[3] = 8'h03;
    flen = 4; fbits = 0;
    send_frame();
    check_status("overrun");
    strobe("overrun_strobe");

    // Partial byte at cs rise.
    fbuf[0] = 8'h00; flen = 1; fbits = 4;
    send_frame();
    check_status("partial");

    // Valid pending frame, then reset in the middle of the next frame.
    fbuf[0] = 8'h03; fbuf[1] = 8'h44; flen = 2; fbits = 0;
    send_frame();
    check_status("prereset");
    cs = 1'b0;
    #80;
    for (int k = 0; k < 3; k++) send_bit(1'b1);
    @(negedge clk);
    resetN = 1'b0;
    cs = 1'b1;
    model_reset();
    @(negedge clk);
    check_status("midreset");
    check("midreset_upd", W'(coefUpdated), W'(0));
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    repeat (4) @(negedge clk);
    strobe("postreset_strobe");

`ifdef SYMMETRIC_COEF_EN
    fbuf[0] = 8'h02; fbuf[1] = 8'h33; flen = 2; fbits = 0;
    send_frame();
    strobe("sym_strobe");
    check("sym_tap2", W'(coefs[2*8 +: 8]), W'(8'h33));
    check("sym_tap10", W'(coefs[10*8 +: 8]), W'(8'h33));
`endif

    // Randomised frames.
    for (int it = 0; it < 25; it++) begin
      flen = $urandom_range(0, 14);
      fbuf[0] = 8'($urandom_range(0, 15));
      for (int k = 1; k < flen; k++) fbuf[k] = 8'($urandom);
      fbits = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
      send_frame();
      check_status("rand");
      if ($urandom_range(0, 1) == 1) strobe("rand_strobe");
    end
    strobe("final_strobe");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
